// File: rtl/control_unit_pkg.sv
// Shared types and encodings for the multi-cycle control unit and its decoder.
// The optional interrupt feature is selected with CU_INTERRUPT_EN.
package control_unit_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_MEM,
    ST_INT
  } state_t;

  localparam logic [6:0] OP_ALU_REG = 7'b1110000;
  localparam logic [6:0] OP_SHIFT   = 7'b1100000;
  localparam logic [6:0] OP_MEM     = 7'b1000000;
  localparam logic [6:0] OP_JUMP    = 7'b1111000;
  localparam logic [6:0] OP_BRANCH  = 7'b1111110;

  localparam logic [2:0] FN_JMP  = 3'b000;
  localparam logic [2:0] FN_CALL = 3'b100;
  localparam logic [2:0] FN_BEQ  = 3'b000;
  localparam logic [2:0] FN_BNE  = 3'b001;
  localparam logic [2:0] FN_BLT  = 3'b010;
  localparam logic [2:0] FN_BGE  = 3'b011;
  localparam logic [2:0] FN_RET  = 3'b100;
  localparam logic [2:0] FN_RETI = 3'b101;

  typedef enum logic [3:0] {
    PC_INC  = 4'b0000,
    PC_BEQ  = 4'b0001,
    PC_BNE  = 4'b0010,
    PC_BLT  = 4'b0011,
    PC_BGE  = 4'b0100,
    PC_JMP  = 4'b0101,
    PC_CALL = 4'b0110,
    PC_RET  = 4'b0111,
    PC_RETI = 4'b1000,
    PC_INT  = 4'b1001
  } pc_op_t;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_MEM  = 2'b01,
    WB_PORT = 2'b10,
    WB_LINK = 2'b11
  } reg_mux_t;

  // Memory-class func[1:0] maps directly onto these kinds.
  typedef enum logic [1:0] {
    MEM_LOAD  = 2'b00,
    MEM_STORE = 2'b01,
    MEM_PIN   = 2'b10,
    MEM_POUT  = 2'b11
  } mem_kind_t;

  typedef struct packed {
    logic      op2_c;
    logic [3:0] alu_op;
    logic      alu_cls;
    pc_op_t    pc_oper;
    logic      ret;
    logic      reti;
    logic      jbs;
    logic      is_mem;
    mem_kind_t mem_kind;
  } decode_t;

endpackage

// File: rtl/control_decoder.sv
// Purely combinational opcode/function decode into datapath controls.
// With CU_INTERRUPT_EN undefined, RETI decodes as a plain RET.
module control_decoder
  import control_unit_pkg::*;
(
  input  logic [6:0] op,
  input  logic [2:0] func,
  output decode_t    dec
);

  always_comb begin
    // NOTE: assign every field a default first so no path leaves dec unassigned (no latch).
    dec = '0;
    if (!op[6]) begin
      dec.op2_c   = 1'b1;
      dec.alu_op  = {1'b0, func};
      dec.alu_cls = 1'b1;
    end else begin
      unique case (op)
        OP_ALU_REG: begin
          dec.alu_op  = {1'b0, func};
          dec.alu_cls = 1'b1;
        end
        OP_SHIFT: begin
          dec.alu_op  = {2'b10, func[1:0]};
          dec.alu_cls = 1'b1;
        end
        OP_MEM: begin
          dec.is_mem   = ~func[2];
          dec.mem_kind = mem_kind_t'(func[1:0]);
        end
        OP_JUMP: begin
          if (func == FN_JMP) begin
            dec.pc_oper = PC_JMP;
          end else if (func == FN_CALL) begin
            dec.pc_oper = PC_CALL;
            dec.jbs     = 1'b1;
          end
        end
        OP_BRANCH: begin
          unique case (func)
            FN_BEQ: dec.pc_oper = PC_BEQ;
            FN_BNE: dec.pc_oper = PC_BNE;
            FN_BLT: dec.pc_oper = PC_BLT;
            FN_BGE: dec.pc_oper = PC_BGE;
            FN_RET: begin
              dec.pc_oper = PC_RET;
              dec.ret     = 1'b1;
            end
            FN_RETI: begin
`ifdef CU_INTERRUPT_EN
              dec.pc_oper = PC_RETI;
              dec.reti    = 1'b1;
`else
              dec.pc_oper = PC_RET;
              dec.ret     = 1'b1;
`endif
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control unit: FETCH/EXEC/MEM/INT sequencing and bus handshakes.
// Define CU_INTERRUPT_EN to enable interrupt entry, the in-service flag and RETI.
module control_unit
  import control_unit_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       int_req,
  input  logic       inst_ack_i,
  input  logic [6:0] op_i,
  input  logic [2:0] func_i,
  input  logic       data_ack_i,
  output logic       op2_c,
  output logic [3:0] ALUOp_o,
  output logic       ALUFR_o,
  output logic       ALUEN_o,
  output logic       RegWrt_o,
  output logic [1:0] RegMux_c,
  output logic       PCEN_o,
  output logic [3:0] PCoper_o,
  output logic       ret_o,
  output logic       reti_o,
  output logic       jbs_o,
  output logic       DPMUX_o,
  output logic       int_o,
  output logic       int_ack_o,
  output logic       stb_o,
  output logic       cyc_o,
  output logic       data_stb_o,
  output logic       data_cyc_o,
  output logic       data_we_o,
  output logic       port_we_o
);

  state_t  state;
  decode_t dec;
  logic    pending;

  control_decoder u_decoder (
    .op  (op_i),
    .func(func_i),
    .dec (dec)
  );

`ifdef CU_INTERRUPT_EN
  logic in_service;

  assign pending = int_req & ~in_service;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_service <= 1'b0;
    end else if (state == ST_INT) begin
      in_service <= 1'b1;
    end else if (state == ST_EXEC && dec.reti) begin
      in_service <= 1'b0;
    end
  end
`else
  logic unused_int_req;

  assign unused_int_req = int_req;
  assign pending        = 1'b0;
`endif

  // Interrupts are only considered at an instruction boundary (EXEC or MEM-ack exit).
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE:  state <= ST_FETCH;
        ST_FETCH: if (inst_ack_i) state <= ST_EXEC;
        ST_EXEC: begin
          if (dec.is_mem)   state <= ST_MEM;
          else if (pending) state <= ST_INT;
          else              state <= ST_FETCH;
        end
        ST_MEM:   if (data_ack_i) state <= pending ? ST_INT : ST_FETCH;
        ST_INT:   state <= ST_FETCH;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    op2_c      = 1'b0;
    ALUOp_o    = 4'b0000;
    ALUFR_o    = 1'b0;
    ALUEN_o    = 1'b0;
    RegWrt_o   = 1'b0;
    RegMux_c   = WB_ALU;
    PCEN_o     = 1'b0;
    PCoper_o   = PC_INC;
    ret_o      = 1'b0;
    reti_o     = 1'b0;
    jbs_o      = 1'b0;
    DPMUX_o    = 1'b0;
    int_o      = 1'b0;
    int_ack_o  = 1'b0;
    stb_o      = 1'b0;
    cyc_o      = 1'b0;
    data_stb_o = 1'b0;
    data_cyc_o = 1'b0;
    data_we_o  = 1'b0;
    port_we_o  = 1'b0;
    unique case (state)
      ST_FETCH: begin
        stb_o = 1'b1;
        cyc_o = 1'b1;
      end
      ST_EXEC: begin
        if (!dec.is_mem) begin
          op2_c    = dec.op2_c;
          ALUOp_o  = dec.alu_op;
          ALUEN_o  = dec.alu_cls;
          ALUFR_o  = dec.alu_cls;
          RegWrt_o = dec.alu_cls;
          PCEN_o   = 1'b1;
          PCoper_o = dec.pc_oper;
          ret_o    = dec.ret;
          reti_o   = dec.reti;
          jbs_o    = dec.jbs;
        end
      end
      ST_MEM: begin
        data_cyc_o = 1'b1;
        data_stb_o = 1'b1;
        data_we_o  = (dec.mem_kind == MEM_STORE);
        port_we_o  = (dec.mem_kind == MEM_POUT);
        DPMUX_o    = (dec.mem_kind == MEM_PIN) || (dec.mem_kind == MEM_POUT);
        if (data_ack_i) begin
          PCEN_o = 1'b1;
          if (dec.mem_kind == MEM_LOAD) begin
            RegWrt_o = 1'b1;
            RegMux_c = WB_MEM;
          end else if (dec.mem_kind == MEM_PIN) begin
            RegWrt_o = 1'b1;
            RegMux_c = WB_PORT;
          end
        end
      end
`ifdef CU_INTERRUPT_EN
      ST_INT: begin
        int_o     = 1'b1;
        int_ack_o = 1'b1;
        jbs_o     = 1'b1;
        PCEN_o    = 1'b1;
        PCoper_o  = PC_INT;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: a reactive bus-slave driver pushes expected
// instruction-end vectors, a monitor pops them whenever PCEN_o is presented.
module tb_control_unit;

`ifdef CU_INTERRUPT_EN
  localparam bit INT_EN = 1'b1;
`else
  localparam bit INT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       int_req = 1'b0;
  logic       inst_ack_i = 1'b0;
  logic [6:0] op_i = '0;
  logic [2:0] func_i = '0;
  logic       data_ack_i = 1'b0;
  logic       op2_c, ALUFR_o, ALUEN_o, RegWrt_o, PCEN_o, ret_o, reti_o, jbs_o, DPMUX_o;
  logic       int_o, int_ack_o, stb_o, cyc_o, data_stb_o, data_cyc_o, data_we_o, port_we_o;
  logic [3:0] ALUOp_o, PCoper_o;
  logic [1:0] RegMux_c;

  always #5 clk = ~clk;

  control_unit dut (
    .clk(clk), .rst(rst), .int_req(int_req), .inst_ack_i(inst_ack_i),
    .op_i(op_i), .func_i(func_i), .data_ack_i(data_ack_i),
    .op2_c(op2_c), .ALUOp_o(ALUOp_o), .ALUFR_o(ALUFR_o), .ALUEN_o(ALUEN_o),
    .RegWrt_o(RegWrt_o), .RegMux_c(RegMux_c), .PCEN_o(PCEN_o), .PCoper_o(PCoper_o),
    .ret_o(ret_o), .reti_o(reti_o), .jbs_o(jbs_o), .DPMUX_o(DPMUX_o),
    .int_o(int_o), .int_ack_o(int_ack_o), .stb_o(stb_o), .cyc_o(cyc_o),
    .data_stb_o(data_stb_o), .data_cyc_o(data_cyc_o), .data_we_o(data_we_o),
    .port_we_o(port_we_o)
  );

  typedef struct packed {
    logic       op2_c;
    logic [3:0] alu_op;
    logic       alufr;
    logic       aluen;
    logic       regwrt;
    logic [1:0] regmux;
    logic       pcen;
    logic [3:0] pcoper;
    logic       ret;
    logic       reti;
    logic       jbs;
    logic       dpmux;
    logic       irq_o;
    logic       irq_ack;
    logic       stb;
    logic       cyc;
    logic       dstb;
    logic       dcyc;
    logic       dwe;
    logic       pwe;
  } outs_t;

  typedef struct packed {
    logic [6:0] op;
    logic [2:0] fn;
    logic       irq;
  } stim_t;

  outs_t exp_q[$];
  int    vectors = 0;
  int    miscompares = 0;
  bit    isf = 1'b0;
  bit    done = 1'b0;

  function automatic outs_t sample();
    outs_t o;
    o = '{op2_c, ALUOp_o, ALUFR_o, ALUEN_o, RegWrt_o, RegMux_c, PCEN_o, PCoper_o,
          ret_o, reti_o, jbs_o, DPMUX_o, int_o, int_ack_o, stb_o, cyc_o,
          data_stb_o, data_cyc_o, data_we_o, port_we_o};
    return o;
  endfunction

  // Reference model: instruction classes straight from the opcode/func tables.
  function automatic bit is_mem_op(input logic [6:0] op, input logic [2:0] fn);
    return op == 7'b1000000 && fn < 3'd4;
  endfunction

  function automatic outs_t end_vec(input logic [6:0] op, input logic [2:0] fn);
    outs_t o;
    bit    alu;
    o = '0;
    alu = 1'b0;
    o.pcen = 1'b1;
    if (op < 7'd64) begin
      o.op2_c = 1'b1; o.alu_op = {1'b0, fn}; alu = 1'b1;
    end else if (op == 7'b1110000) begin
      o.alu_op = {1'b0, fn}; alu = 1'b1;
    end else if (op == 7'b1100000) begin
      o.alu_op = 4'd8 + 4'(fn % 4); alu = 1'b1;
    end else if (is_mem_op(op, fn)) begin
      o.dstb = 1'b1; o.dcyc = 1'b1;
      case (fn)
        3'd0: begin o.regwrt = 1'b1; o.regmux = 2'd1; end
        3'd1: o.dwe = 1'b1;
        3'd2: begin o.dpmux = 1'b1; o.regwrt = 1'b1; o.regmux = 2'd2; end
        default: begin o.dpmux = 1'b1; o.pwe = 1'b1; end
      endcase
    end else if (op == 7'b1111000) begin
      if (fn == 3'd0) o.pcoper = 4'd5;
      if (fn == 3'd4) begin o.pcoper = 4'd6; o.jbs = 1'b1; end
    end else if (op == 7'b1111110) begin
      if (fn < 3'd4) o.pcoper = 4'(fn) + 4'd1;
      else if (fn == 3'd4 || (fn == 3'd5 && !INT_EN)) begin o.pcoper = 4'd7; o.ret = 1'b1; end
      else if (fn == 3'd5) begin o.pcoper = 4'd8; o.reti = 1'b1; end
    end
    if (alu) begin o.aluen = 1'b1; o.alufr = 1'b1; o.regwrt = 1'b1; end
    return o;
  endfunction

  function automatic outs_t int_vec();
    outs_t o;
    o = '0;
    o.irq_o = 1'b1; o.irq_ack = 1'b1; o.jbs = 1'b1; o.pcen = 1'b1; o.pcoper = 4'd9;
    return o;
  endfunction

  function automatic outs_t fetch_vec();
    outs_t o;
    o = '0;
    o.stb = 1'b1; o.cyc = 1'b1;
    return o;
  endfunction

  task automatic check(input string name, input outs_t act, input outs_t exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_for(input bit want_data, output bit ok);
    int n;
    n = 0;
    ok = 1'b1;
    while (want_data ? !data_cyc_o : !(stb_o && cyc_o)) begin
      tick();
      n++;
      if (n > 16) begin
        vectors++;
        miscompares++;
        $display("FAIL timeout waiting for %s bus cycle @%0t", want_data ? "data" : "fetch", $time);
        ok = 1'b0;
        return;
      end
    end
  endtask

  task automatic run_instr(input stim_t s, input int mem_delay, output bit ok);
    bit    take;
    outs_t hold;
    wait_for(1'b0, ok);
    if (!ok) return;
    check("fetch", sample(), fetch_vec());
    repeat ($urandom_range(0, 2)) tick();
    op_i = s.op;
    func_i = s.fn;
    int_req = s.irq;
    inst_ack_i = 1'b1;
    exp_q.push_back(end_vec(s.op, s.fn));
    take = INT_EN && s.irq && !isf;
    if (take) exp_q.push_back(int_vec());
    if (INT_EN && s.op == 7'b1111110 && s.fn == 3'd5) isf = 1'b0;
    if (take) isf = 1'b1;
    tick();
    inst_ack_i = 1'b0;
    if (is_mem_op(s.op, s.fn)) begin
      wait_for(1'b1, ok);
      if (!ok) return;
      hold = end_vec(s.op, s.fn);
      hold.pcen = 1'b0; hold.regwrt = 1'b0; hold.regmux = 2'd0;
      for (int i = 0; i < mem_delay; i++) begin
        check("mem_hold", sample(), hold);
        tick();
      end
      data_ack_i = 1'b1;
      tick();
      data_ack_i = 1'b0;
    end
  endtask

  initial begin
    stim_t dir [18];
    stim_t s;
    bit    ok;
    outs_t e;
    logic [5:0] r6;
    dir = '{
      '{7'b1110000, 3'b011, 1'b0}, '{7'b0001000, 3'b010, 1'b0}, '{7'b1100000, 3'b011, 1'b0},
      '{7'b1000000, 3'b000, 1'b0}, '{7'b1000000, 3'b001, 1'b0}, '{7'b1000000, 3'b010, 1'b0},
      '{7'b1000000, 3'b011, 1'b0}, '{7'b1111000, 3'b100, 1'b0}, '{7'b1111110, 3'b001, 1'b0},
      '{7'b1110000, 3'b000, 1'b1}, '{7'b1110000, 3'b000, 1'b1}, '{7'b1111110, 3'b101, 1'b1},
      '{7'b1110000, 3'b001, 1'b1}, '{7'b1111110, 3'b101, 1'b0}, '{7'b1000000, 3'b000, 1'b1},
      '{7'b1111110, 3'b101, 1'b0}, '{7'b1111000, 3'b000, 1'b0}, '{7'b1000000, 3'b100, 1'b0}
    };
    fork
      begin
        // Reset with inst_ack held high; the first fetched word is a NOP.
        inst_ack_i = 1'b1;
        op_i = 7'b1010101;
        func_i = 3'b000;
        tick();
        check("reset_outputs", sample(), outs_t'('0));
        tick();
        check("reset_outputs", sample(), outs_t'('0));
        exp_q.push_back(end_vec(7'b1010101, 3'b000));
        rst = 1'b1;
        #1;
        check("idle_after_release", sample(), outs_t'('0));
        tick();
        check("first_fetch", sample(), fetch_vec());
        tick();
        inst_ack_i = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 18 && ok; i++) run_instr(dir[i], 3, ok);
        for (int i = 0; i < 300 && ok; i++) begin
          r6 = 6'($urandom);
          s.fn = 3'($urandom);
          s.irq = ($urandom_range(0, 3) == 0);
          case ($urandom_range(0, 6))
            0: s.op = {1'b0, r6};
            1: s.op = 7'b1110000;
            2: s.op = 7'b1100000;
            3: s.op = 7'b1000000;
            4: s.op = 7'b1111000;
            5: s.op = 7'b1111110;
            default: s.op = {1'b1, r6};
          endcase
          run_instr(s, $urandom_range(0, 3), ok);
        end
        tick();
        tick();
        vectors++;
        if (exp_q.size() != 0) begin
          miscompares++;
          $display("FAIL scoreboard_drain: %0d expected events never presented", exp_q.size());
        end
        // Asynchronous reset in the middle of a data access drops the strobes at once.
        if (ok) begin
          wait_for(1'b0, ok);
          if (ok) begin
            op_i = 7'b1000000;
            func_i = 3'b000;
            int_req = 1'b0;
            inst_ack_i = 1'b1;
            exp_q.push_back(end_vec(7'b1000000, 3'b000));
            tick();
            inst_ack_i = 1'b0;
            wait_for(1'b1, ok);
            #3;
            rst = 1'b0;
            #1;
            check("async_abort", sample(), outs_t'('0));
            exp_q.delete();
            isf = 1'b0;
          end
        end
        done = 1'b1;
        tick();
      end
      begin
        while (!done) begin
          @(negedge clk);
          if (rst && PCEN_o && !done) begin
            if (exp_q.size() == 0) begin
              vectors++;
              miscompares++;
              $display("FAIL unexpected_pcen @%0t: got %h with no event expected", $time, sample());
            end else begin
              e = exp_q.pop_front();
              check("pcen_event", sample(), e);
            end
          end
        end
      end
    join
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
